rot_reset_sequencer: RTL and testbench
======================================

Name: rot_reset_sequencer

Overview:
- Receiving end of the RoT monitors' kill/reset request lines.
- Merges the level requests from all hardware monitors and drives the CPU reset for a guaranteed minimum duration.
- Confirms the CPU refetches from the reset handler and latches a sticky cause vector plus a saturating violation counter for the attestation report.
- Sits between the monitor bank and the openMSP430 PUC/reset input.

Parameters:
NREQ, 3, number of monitor request lines
HOLD_CYCLES, 16, cycles cpu_rst is held high per assertion (>=2)
FETCH_TIMEOUT, 64, max cycles after release to observe pc==RESET_HANDLER before re-asserting
RESET_HANDLER, 16'hFFFE, PC value proving the CPU restarted
CNT_W, 8, width of violation and retry counters

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_vec  input  NREQ  level reset requests from monitors; bit i high = monitor i in KILL
pc  input  16  current CPU program counter
clr  input  1  single-cycle pulse; clears cause and counters (honoured only in IDLE)
cpu_rst  output  1  registered reset to CPU
busy  output  1  high in any state other than IDLE
cause  output  NREQ  sticky OR of every req_vec bit seen since last clear
viol_cnt  output  CNT_W  saturating count of violation episodes
retry_cnt  output  CNT_W  saturating count of FETCH timeouts

Behaviour:
- Async reset: state=IDLE; cpu_rst=0, busy=0, cause=0, viol_cnt=0, retry_cnt=0; hold/timeout counters=0. Reset mid-episode aborts it immediately.
- All outputs registered. cpu_rst rises one cycle after the first cycle |req_vec is sampled high in IDLE.
- States:
  - IDLE: cpu_rst=0.
    - |req_vec -> ASSERT; cause<=cause|req_vec; viol_cnt+1 (saturating); hold_cnt<=0.
    - Else if clr -> cause<=0, viol_cnt<=0, retry_cnt<=0.
    - clr and req in the same cycle: clear first, then apply the request (cause=req_vec, viol_cnt=1).
  - ASSERT: cpu_rst=1. cause|=req_vec every cycle. hold_cnt increments.
    - At hold_cnt==HOLD_CYCLES-1 -> FETCH with tmo_cnt<=0.
    - cpu_rst high exactly HOLD_CYCLES cycles.
  - FETCH: cpu_rst=0. req_vec staying high is expected here and does not count as a new episode; cause|=req_vec.
    - pc==RESET_HANDLER -> DRAIN.
    - Else at tmo_cnt==FETCH_TIMEOUT-1 -> ASSERT, retry_cnt+1 (saturating), hold_cnt<=0.
    - PC match on the timeout cycle: the match wins.
  - DRAIN (one cycle; monitors drop their request the cycle after they see the handler PC):
    - req_vec==0 -> IDLE.
    - Else -> ASSERT, viol_cnt+1 (saturating), cause|=req_vec. This is a new violation.
- clr is ignored outside IDLE.
- Counters saturate at all-ones and never wrap.
- busy = (state != IDLE), registered with the state.
- Unknown or illegal state encoding -> IDLE.

Test Plan:
- Reset check: after async reset -> all outputs 0. Pulse reset mid-ASSERT -> cpu_rst=0 and busy=0 immediately, cause=0.
- Basic episode (defaults): req_vec=3'b001 rises at cycle 10, drops the cycle after pc=16'hFFFE is presented at 5 cycles post-release.
  - cpu_rst high cycles 11..26.
  - State returns to IDLE; cause=001, viol_cnt=1, retry_cnt=0.
- Timeout retry: pc never 16'hFFFE.
  - cpu_rst re-asserts after 64 low cycles; retry_cnt increments each loop.
  - Three loops -> retry_cnt=3, viol_cnt=1.
- Cause merge and re-violation:
  - req 001 then 100 during ASSERT -> cause=101.
  - req_vec still 010 in DRAIN -> re-ASSERT, viol_cnt=2, cause=111.
- Saturation and clear: CNT_W=2, five episodes -> viol_cnt=3.
  - clr while busy -> no change.
  - clr in IDLE -> all cleared.
  - clr coinciding with req=010 -> cause=010, viol_cnt=1.

Source files
------------

// File: rtl/rot_reset_sequencer.sv
// Reset sequencer fed by the RoT monitors: merges kill requests, holds the CPU
// in reset, confirms the refetch from the reset handler and keeps attestation stats.
module rot_reset_sequencer #(
    parameter int          NREQ          = 3,
    parameter int          HOLD_CYCLES   = 16,
    parameter int          FETCH_TIMEOUT = 64,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_vec,
    input  logic [15:0]      pc,
    input  logic             clr,
    output logic             cpu_rst,
    output logic             busy,
    output logic [NREQ-1:0]  cause,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TMO_W  = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_FETCH  = 2'b10,
        ST_DRAIN  = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic [NREQ-1:0]   cause_s;
    logic [CNT_W-1:0]  viol_cnt_s, retry_cnt_s;
    logic              any_req_s;

    // Counters stick at all-ones so the attestation report never sees a wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1'b1);
        end
    endfunction

    assign any_req_s = |req_vec;

    // Next-state, counter and statistics logic.
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        tmo_cnt_s   = tmo_cnt_r;
        cause_s     = cause;
        viol_cnt_s  = viol_cnt;
        retry_cnt_s = retry_cnt;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s    = ST_ASSERT;
                    hold_cnt_s = '0;
                    if (clr) begin
                        // Clear first, then record the new request on top.
                        cause_s     = req_vec;
                        viol_cnt_s  = CNT_W'(1'b1);
                        retry_cnt_s = '0;
                    end else begin
                        cause_s    = cause | req_vec;
                        viol_cnt_s = sat_inc(viol_cnt);
                    end
                end else if (clr) begin
                    cause_s     = '0;
                    viol_cnt_s  = '0;
                    retry_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                cause_s = cause | req_vec;
                if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_s   = ST_FETCH;
                    tmo_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1'b1);
                end
            end
            ST_FETCH: begin
                // Requests still high here belong to the current episode.
                cause_s = cause | req_vec;
                if (pc == RESET_HANDLER) begin
                    state_s = ST_DRAIN;
                end else if (tmo_cnt_r == TMO_W'(FETCH_TIMEOUT - 1)) begin
                    state_s     = ST_ASSERT;
                    hold_cnt_s  = '0;
                    retry_cnt_s = sat_inc(retry_cnt);
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1'b1);
                end
            end
            ST_DRAIN: begin
                cause_s = cause | req_vec;
                if (!any_req_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s    = ST_ASSERT;
                    hold_cnt_s = '0;
                    viol_cnt_s = sat_inc(viol_cnt);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            cpu_rst    <= 1'b0;
            busy       <= 1'b0;
            cause      <= '0;
            viol_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            tmo_cnt_r  <= tmo_cnt_s;
            cpu_rst    <= (state_s == ST_ASSERT);
            busy       <= (state_s != ST_IDLE);
            cause      <= cause_s;
            viol_cnt   <= viol_cnt_s;
            retry_cnt  <= retry_cnt_s;
        end
    end

endmodule

// File: tb/tb_rot_reset_sequencer.sv
// Directed scoreboard bench: a default instance plus a narrow-counter
// instance (CNT_W=2, short hold/timeout) for saturation and clear cases.
module tb_rot_reset_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_vec, req2;
    logic [15:0] pc, pc2;
    logic        clr, clr2;
    logic        cpu_rst, busy, cpu_rst2, busy2;
    logic [2:0]  cause, cause2;
    logic [7:0]  viol_cnt, retry_cnt;
    logic [1:0]  viol2, retry2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       cpu_rst;
        logic       busy;
        logic [2:0] cause;
        logic [7:0] viol;
        logic [7:0] retry;
        bit         sat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rot_reset_sequencer dut (
        .clk(clk), .reset(reset), .req_vec(req_vec), .pc(pc), .clr(clr),
        .cpu_rst(cpu_rst), .busy(busy), .cause(cause),
        .viol_cnt(viol_cnt), .retry_cnt(retry_cnt)
    );

    rot_reset_sequencer #(.HOLD_CYCLES(4), .FETCH_TIMEOUT(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req_vec(req2), .pc(pc2), .clr(clr2),
        .cpu_rst(cpu_rst2), .busy(busy2), .cause(cause2),
        .viol_cnt(viol2), .retry_cnt(retry2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic r, input logic b, input logic [2:0] c,
                        input logic [7:0] v, input logic [7:0] t, input bit s);
        exp_t e;
        e.tag = tag; e.cpu_rst = r; e.busy = b; e.cause = c; e.viol = v; e.retry = t; e.sat = s;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            if (e.sat) begin
                chk({e.tag, ".cpu_rst"}, {15'd0, cpu_rst2}, {15'd0, e.cpu_rst});
                chk({e.tag, ".busy"}, {15'd0, busy2}, {15'd0, e.busy});
                chk({e.tag, ".cause"}, {13'd0, cause2}, {13'd0, e.cause});
                chk({e.tag, ".viol"}, {14'd0, viol2}, {8'd0, e.viol});
                chk({e.tag, ".retry"}, {14'd0, retry2}, {8'd0, e.retry});
            end else begin
                chk({e.tag, ".cpu_rst"}, {15'd0, cpu_rst}, {15'd0, e.cpu_rst});
                chk({e.tag, ".busy"}, {15'd0, busy}, {15'd0, e.busy});
                chk({e.tag, ".cause"}, {13'd0, cause}, {13'd0, e.cause});
                chk({e.tag, ".viol"}, {8'd0, viol_cnt}, {8'd0, e.viol});
                chk({e.tag, ".retry"}, {8'd0, retry_cnt}, {8'd0, e.retry});
            end
        end
    endtask

    // Returns the number of consecutive cycles cpu_rst stays at level lvl.
    task automatic count_level(input logic lvl, input int bound, output int n);
        n = 0;
        while (cpu_rst === lvl && n < bound) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; req_vec = 3'b000; pc = 16'h0000; clr = 1'b0;
        req2 = 3'b000; pc2 = 16'hFFFE; clr2 = 1'b0;
        repeat (3) tick();
        push("rst", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b0); pop_check();
        push("rst_sat", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b1); pop_check();
        reset = 1'b0;

        // Basic episode
        repeat (9) tick();
        req_vec = 3'b001;
        push("bas_assert", 1'b1, 1'b1, 3'b001, 8'd1, 8'd0, 1'b0);
        tick(); pop_check();
        count_level(1'b1, 100, n);
        chk("bas_hold", 16'(n), 16'd16);
        repeat (4) tick();
        pc = 16'hFFFE;
        push("bas_drain", 1'b0, 1'b1, 3'b001, 8'd1, 8'd0, 1'b0);
        tick(); pop_check();
        req_vec = 3'b000; pc = 16'h0000;
        push("bas_idle", 1'b0, 1'b0, 3'b001, 8'd1, 8'd0, 1'b0);
        tick(); pop_check();

        // Timeout retries
        clr = 1'b1;
        push("clr1", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b0);
        tick(); pop_check();
        clr = 1'b0;
        req_vec = 3'b001;
        tick();
        for (int k = 1; k <= 3; k++) begin
            count_level(1'b1, 100, n);
            chk("tmo_hold", 16'(n), 16'd16);
            count_level(1'b0, 200, n);
            chk("tmo_low", 16'(n), 16'd64);
            chk("tmo_retry", {8'd0, retry_cnt}, 16'(k));
        end
        count_level(1'b1, 100, n);
        pc = 16'hFFFE;
        tick();
        req_vec = 3'b000; pc = 16'h0000;
        push("tmo_idle", 1'b0, 1'b0, 3'b001, 8'd1, 8'd3, 1'b0);
        tick(); pop_check();

        // Cause merge, busy clr ignored, re-violation in DRAIN
        clr = 1'b1;
        push("clr2", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b0);
        tick(); pop_check();
        clr = 1'b0;
        req_vec = 3'b001;
        tick();
        repeat (3) tick();
        req_vec = 3'b100;
        tick();
        req_vec = 3'b000;
        push("mrg_cause", 1'b1, 1'b1, 3'b101, 8'd1, 8'd0, 1'b0);
        tick(); pop_check();
        clr = 1'b1;
        push("busy_clr", 1'b1, 1'b1, 3'b101, 8'd1, 8'd0, 1'b0);
        tick(); pop_check();
        clr = 1'b0;
        count_level(1'b1, 100, n);
        req_vec = 3'b010;
        tick();
        pc = 16'hFFFE;
        tick();
        pc = 16'h0000;
        push("re_viol", 1'b1, 1'b1, 3'b111, 8'd2, 8'd0, 1'b0);
        tick(); pop_check();
        req_vec = 3'b000;
        count_level(1'b1, 100, n);
        chk("re_hold", 16'(n), 16'd16);
        pc = 16'hFFFE;
        tick();
        pc = 16'h0000;
        push("mrg_idle", 1'b0, 1'b0, 3'b111, 8'd2, 8'd0, 1'b0);
        tick(); pop_check();

        // Async reset in the middle of ASSERT
        req_vec = 3'b001;
        tick(); tick();
        chk("pre_rst_assert", {15'd0, cpu_rst}, 16'd1);
        reset = 1'b1;
        #1;
        push("rst_mid", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b0); pop_check();
        req_vec = 3'b000;
        tick();
        reset = 1'b0;
        tick();

        // Saturation on the narrow instance
        for (int k = 1; k <= 5; k++) begin
            req2 = 3'b001;
            tick();
            req2 = 3'b000;
            repeat (8) tick();
            push("sat_viol", 1'b0, 1'b0, 3'b001, (k > 3) ? 8'd3 : 8'(k), 8'd0, 1'b1);
            pop_check();
        end
        req2 = 3'b001;
        tick();
        req2 = 3'b000;
        clr2 = 1'b1;
        push("sat_busy_clr", 1'b1, 1'b1, 3'b001, 8'd3, 8'd0, 1'b1);
        tick(); pop_check();
        clr2 = 1'b0;
        repeat (8) tick();
        clr2 = 1'b1; req2 = 3'b010;
        push("sat_clr_req", 1'b1, 1'b1, 3'b010, 8'd1, 8'd0, 1'b1);
        tick(); pop_check();
        clr2 = 1'b0; req2 = 3'b000;
        repeat (8) tick();
        clr2 = 1'b1;
        push("sat_clr_idle", 1'b0, 1'b0, 3'b000, 8'd0, 8'd0, 1'b1);
        tick(); pop_check();
        clr2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
